// File: rtl/mpg_if.sv
// Bus bundle between the config/trigger side and multi_pulse_gen.
interface mpg_if #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned GPIO_PER = 6,
    parameter int unsigned REP_W    = 8
);
    logic                         trig_in;
    logic                         abort;
    logic [NUM_CH*CNT_W-1:0]      ch_start;
    logic [NUM_CH*CNT_W-1:0]      ch_end;
    logic [CNT_W-1:0]             period;
    logic [REP_W-1:0]             rep_cnt;
    logic [NUM_CH*GPIO_PER-1:0]   gpio;
    logic                         busy;
    logic                         done;
    logic                         cfg_err;

    modport master (
        output trig_in, abort, ch_start, ch_end, period, rep_cnt,
        input  gpio, busy, done, cfg_err
    );

    modport slave (
        input  trig_in, abort, ch_start, ch_end, period, rep_cnt,
        output gpio, busy, done, cfg_err
    );
endinterface

// File: rtl/multi_pulse_gen.sv
// N-channel windowed pulse generator started by a falling edge on an async trigger.
// Optional burst repeat of the frame is enabled with `define MPG_REPEAT_EN.
module multi_pulse_gen #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned GPIO_PER = 6,
    parameter int unsigned REP_W    = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    mpg_if.slave  bus
);
    localparam int unsigned WIN_W = NUM_CH * CNT_W;
    localparam int unsigned GPIO_W = NUM_CH * GPIO_PER;

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [2:0]          sync_q, sync_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIN_W-1:0]    start_s_q, start_s_d;
    logic [WIN_W-1:0]    end_s_q, end_s_d;
    logic [CNT_W-1:0]    period_s_q, period_s_d;
    logic [REP_W-1:0]    rep_left_q, rep_left_d;
    logic [GPIO_W-1:0]   gpio_q, gpio_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cfg_err_q, cfg_err_d;

    logic trig_fe_c;
    logic frame_end_c;
    logic load_c;
    logic reject_c;
    logic wrap_c;
    logic finish_c;

    // sync_q[0..2] = s1..s3; edge detect on the last two stages
    assign sync_d    = {sync_q[1:0], bus.trig_in};
    assign trig_fe_c = ~sync_q[1] & sync_q[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sync_q     <= 3'b111;
            cnt_q      <= '0;
            start_s_q  <= '0;
            end_s_q    <= '0;
            period_s_q <= '0;
            rep_left_q <= '0;
            gpio_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            start_s_q  <= start_s_d;
            end_s_q    <= end_s_d;
            period_s_q <= period_s_d;
            rep_left_q <= rep_left_d;
            gpio_q     <= gpio_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // Next state; abort outranks trigger, trigger outranks frame end
    always_comb begin
        state_d     = state_q;
        load_c      = 1'b0;
        reject_c    = 1'b0;
        wrap_c      = 1'b0;
        finish_c    = 1'b0;
        frame_end_c = (cnt_q == (period_s_q - CNT_W'(1)));
        if (bus.abort) begin
            state_d = ST_IDLE;
        end else if (trig_fe_c) begin
            if (bus.period != '0) begin
                state_d = ST_RUN;
                load_c  = 1'b1;
            end else begin
                state_d  = ST_IDLE;
                reject_c = 1'b1;
            end
        end else if ((state_q == ST_RUN) && frame_end_c) begin
            if (rep_left_q != '0) begin
                wrap_c = 1'b1;
            end else begin
                state_d  = ST_IDLE;
                finish_c = 1'b1;
            end
        end
    end

    // Datapath and registered outputs
    always_comb begin
        cnt_d      = cnt_q;
        start_s_d  = start_s_q;
        end_s_d    = end_s_q;
        period_s_d = period_s_q;
        rep_left_d = rep_left_q;
        gpio_d     = '0;
        busy_d     = (state_d == ST_RUN);
        done_d     = finish_c;
        cfg_err_d  = reject_c;

        if (load_c) begin
            start_s_d  = bus.ch_start;
            end_s_d    = bus.ch_end;
            period_s_d = bus.period;
            cnt_d      = '0;
`ifdef MPG_REPEAT_EN
            rep_left_d = bus.rep_cnt;
`else
            rep_left_d = '0;
`endif
        end else if (state_d == ST_IDLE) begin
            cnt_d = '0;
        end else if (wrap_c) begin
            cnt_d      = '0;
            rep_left_d = rep_left_q - REP_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Window compare on the current count; cleared when abort/reject ends the frame
        if ((state_q == ST_RUN) && !bus.abort && !reject_c) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if ((start_s_q[i*CNT_W +: CNT_W] <= cnt_q) &&
                    (cnt_q < end_s_q[i*CNT_W +: CNT_W])) begin
                    gpio_d[i*GPIO_PER +: GPIO_PER] = '1;
                end
            end
        end
    end

    assign bus.gpio    = gpio_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Directed bench for multi_pulse_gen: per-cycle expected output vectors are queued
// when each trigger is issued and compared on the falling clock edge.
module tb_multi_pulse_gen;
    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned GPIO_PER = 6;
    localparam int unsigned REP_W    = 8;
    localparam int unsigned VW       = NUM_CH * GPIO_PER + 3;

    typedef logic [VW-1:0] vec_t;
    typedef struct {
        logic [127:0] tag;
        int           cyc;
        vec_t         vec;
    } sb_entry_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   st_m [NUM_CH];
    int   en_m [NUM_CH];
    sb_entry_t sb[$];
    sb_entry_t e;
    vec_t      obs;

    mpg_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .GPIO_PER(GPIO_PER), .REP_W(REP_W)) bus ();

    multi_pulse_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .GPIO_PER(GPIO_PER), .REP_W(REP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every entry due at or before this cycle is compared
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            obs = {bus.gpio, bus.busy, bus.done, bus.cfg_err};
            checks++;
            assert (e.cyc == cyc && obs === e.vec) else begin
                errors++;
                $error("FAIL %0s cyc=%0d due=%0d observed=%h expected=%h", e.tag, cyc, e.cyc, obs, e.vec);
            end
        end
    end

    task automatic chk(input logic [127:0] tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %0s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push_vec(input logic [127:0] tag, input int c, input vec_t v);
        sb_entry_t x;
        x.tag = tag;
        x.cyc = c;
        x.vec = v;
        sb.push_back(x);
    endtask

    // Expected outputs for frame starting (cnt=0) at cycle f, entries for offsets 0..r_max
    task automatic push_frame(input logic [127:0] tag, input int f, input int per, input int r_max,
                              input int run_len, input bit with_done, input bit kill_last);
        vec_t v;
        int   c;
        for (int r = 0; r <= r_max; r++) begin
            v = '0;
            if (r >= 1 && (r - 1) < run_len && !(kill_last && r == run_len)) begin
                c = (r - 1) % per;
                for (int ch = 0; ch < int'(NUM_CH); ch++)
                    if (st_m[ch] <= c && c < en_m[ch]) v[3 + ch*GPIO_PER +: GPIO_PER] = '1;
            end
            v[2] = (r < run_len);
            v[1] = with_done && (r == run_len);
            v[0] = 1'b0;
            push_vec(tag, f + r, v);
        end
    endtask

    task automatic set_ch(input int ch, input int s, input int en);
        bus.ch_start[ch*CNT_W +: CNT_W] = CNT_W'(s);
        bus.ch_end[ch*CNT_W +: CNT_W]   = CNT_W'(en);
        st_m[ch] = s;
        en_m[ch] = en;
    endtask

    // Aligns to a falling edge and returns the cycle at which cnt will read 0
    task automatic arm(output int f);
        @(negedge clk);
        f = cyc + 3;
    endtask

    task automatic pulse_trig();
        bus.trig_in = 1'b0;
        repeat (4) @(negedge clk);
        bus.trig_in = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_drain(input logic [127:0] tag);
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL %0s_timeout observed=%0d expected=0 pending", tag, sb.size());
        end
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int f;
        int f2;
        int nfr;
        rst_n          = 1'b0;
        bus.trig_in    = 1'b1;
        bus.abort      = 1'b0;
        bus.ch_start   = '0;
        bus.ch_end     = '0;
        bus.period     = CNT_W'(50);
        bus.rep_cnt    = '0;
        for (int i = 0; i < int'(NUM_CH); i++) set_ch(i, 0, 0);

        #25;
        chk("rst_gpio", 32'(bus.gpio), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single shot, only ch0 active
        set_ch(0, 10, 20);
        arm(f);
        push_frame("t1_single", f, 50, 52, 50, 1'b1, 1'b0);
        pulse_trig();
        wait_drain("t1_single");

        // Window corners: 1-clk, empty, clipped past frame end
        set_ch(1, 0, 1);
        set_ch(2, 30, 30);
        set_ch(3, 40, 60);
        arm(f);
        push_frame("t2_corners", f, 50, 52, 50, 1'b1, 1'b0);
        pulse_trig();
        wait_drain("t2_corners");

        // Abort at cnt=15: outputs clear next clk, no done
        arm(f);
        push_frame("t3_abort", f, 50, 18, 16, 1'b0, 1'b1);
        pulse_trig();
        wait_cyc(f + 15);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        wait_drain("t3_abort");

        // Retrigger landing at cnt=30: frame restarts, single done
        arm(f);
        push_frame("t3_old", f, 50, 30, 1000, 1'b0, 1'b0);
        pulse_trig();
        wait_cyc(f + 28);
        f2 = cyc + 3;
        push_frame("t3_retrig", f2, 50, 52, 50, 1'b1, 1'b0);
        pulse_trig();
        wait_drain("t3_retrig");

        // period==0 is rejected with a one-cycle cfg_err
        bus.period = '0;
        arm(f);
        push_vec("t4_cfg_err", f, vec_t'(1));
        for (int r = 1; r <= 3; r++) push_vec("t4_cfg_idle", f + r, '0);
        pulse_trig();
        wait_drain("t4_cfg_err");
        bus.period = CNT_W'(50);

        // Mid-frame config changes are not seen by the running frame
        arm(f);
        push_frame("t4_shadow", f, 50, 52, 50, 1'b1, 1'b0);
        pulse_trig();
        wait_cyc(f + 5);
        bus.ch_start[0 +: CNT_W] = CNT_W'(5);
        bus.period               = CNT_W'(20);
        wait_drain("t4_shadow");
        bus.ch_start[0 +: CNT_W] = CNT_W'(10);
        bus.period               = CNT_W'(50);

        // Burst repeat
`ifdef MPG_REPEAT_EN
        nfr = 3;
`else
        nfr = 1;
`endif
        bus.rep_cnt = REP_W'(2);
        arm(f);
        push_frame("t5_repeat", f, 50, 50 * nfr + 2, 50 * nfr, 1'b1, 1'b0);
        pulse_trig();
        wait_drain("t5_repeat");
        bus.rep_cnt = '0;

        // Reset at cnt=12 clears outputs without a clock edge
        arm(f);
        push_frame("t6_pre_rst", f, 50, 12, 50, 1'b0, 1'b0);
        pulse_trig();
        wait_cyc(f + 12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_gpio", 32'(bus.gpio), 32'd0);
        chk("t6_rst_busy", 32'(bus.busy), 32'd0);
        chk("t6_rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Normal frame after the mid-frame reset
        arm(f);
        push_frame("t6_post_rst", f, 50, 52, 50, 1'b1, 1'b0);
        pulse_trig();
        wait_drain("t6_post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
